rca_operand_sequencer: RTL and testbench
========================================

Name: rca_operand_sequencer

Overview:
Upstream feeder and result capture stage for the 4-bit ripple-carry adder (half-adder plus three full-adder chain).
- Deserialises operands A and B from a bit-serial valid/ready stream, LSB first.
- Holds both operands stable on the adder inputs for a fixed settle window.
- Registers the adder's sum and carry-out, then presents them on a valid/ready result port.
- Adder instance stays purely combinational, outside this block.

Parameters:
WIDTH, 4, operand width; must match adder width (4).
SETTLE_CYCLES, 1, cycles operands are held with op_valid high before the adder result is sampled; legal range 1..15.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
ser_valid  input  1  serial bit valid
ser_ready  output  1  block accepts a serial bit this cycle
ser_bit  input  1  serial operand bit, A bits first, then B bits, each LSB first
a_out  output  WIDTH  operand A to adder (bit i drives Ai)
b_out  output  WIDTH  operand B to adder (bit i drives Bi)
op_valid  output  1  a_out/b_out complete and stable
sum_in  input  WIDTH  adder sum S3..S0
cout_in  input  1  adder Cout
res_valid  output  1  res_data holds an unconsumed result
res_ready  input  1  downstream accepts result
res_data  output  WIDTH+1  {Cout, S[WIDTH-1:0]}
busy  output  1  high when state is not LOAD_A or bit count is not 0

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst is synchronous, active-high, and has priority over all other activity.
- Reset values:
  - state=LOAD_A, bit_cnt=0, settle_cnt=0.
  - a_out=0, b_out=0, op_valid=0.
  - res_valid=0, res_data=0, busy=0.
  - ser_ready=1 from the first cycle after rst deasserts.
- States: LOAD_A, LOAD_B, SETTLE.
- Transfer rule: a serial transfer occurs on (ser_valid && ser_ready). ser_ready = (state==LOAD_A || state==LOAD_B), decoded from registered state.
- LOAD_A:
  - Each transfer: a_out <= {ser_bit, a_out[WIDTH-1:1]}, bit_cnt++.
  - On the WIDTH-th bit: bit_cnt<=0, go to LOAD_B.
- LOAD_B:
  - Same shifting into b_out.
  - On the WIDTH-th bit: go to SETTLE, settle_cnt<=0, op_valid<=1.
- SETTLE:
  - ser_ready=0; a_out/b_out frozen.
  - settle_cnt increments until it reaches SETTLE_CYCLES-1.
  - At that point, if (!res_valid || res_ready): capture res_data <= {cout_in, sum_in}, res_valid<=1, op_valid<=0, go to LOAD_A.
  - Otherwise, stall in SETTLE with op_valid high until the result slot frees.
  - Capture and drain may coincide in the same cycle: the old result leaves and the new one loads, so res_valid stays 1.
- Result port:
  - res_valid clears on (res_valid && res_ready) with no simultaneous capture.
  - res_data is stable while res_valid && !res_ready.
- Gaps: ser_valid low causes no shift and no count change; gaps are allowed anywhere in the stream.
- Latency: last B bit accepted at edge t → op_valid high from t+1 → res_valid high from t+1+SETTLE_CYCLES (no backpressure).
- Overlap: loading the next operand pair proceeds while the previous result is still held. Only the SETTLE exit stalls on a full result slot.
- Reset mid-operation: partial operands are discarded, a held result is dropped, and all outputs return to reset values.
- Arithmetic: none internal. res_data is the unmodified adder output; max value 0x1E for 0xF+0xF.

Optional Feature:
RCA_PARITY_EN
- Defined:
  - Adds output res_parity (1 bit) = XOR of all res_data bits, registered at capture together with res_data.
  - Reset value 0; held stable while res_valid.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. A=0x9 (bits 1,0,0,1), B=0x7 (bits 1,1,1,0), continuous ser_valid, res_ready=1, adder attached → op_valid with a_out=0x9, b_out=0x7; res_valid 2 cycles after last bit; res_data=5'b10000; parity=1 when enabled.
2. Same stream with ser_valid low for 3 cycles between every bit → identical res_data=0x10; bit_cnt unchanged during gaps.
3. Two back-to-back pairs, 0xF+0xF then 0x1+0x2, res_ready=0 → first res_data=0x1E held; second pair stalls in SETTLE with op_valid=1, ser_ready=0. Raise res_ready for 1 cycle → res_data=0x03 captured the same cycle, res_valid stays 1.
4. rst pulsed after 2 B bits with a prior result held → next cycle res_valid=0, a_out=b_out=0, state LOAD_A. Fresh 0x3+0x4 → res_data=0x07.
5. SETTLE_CYCLES=3, A=0x8, B=0x8 → op_valid high exactly 3 cycles; res_data=5'b10000 at t+4.
6. 0x0+0x0 → res_data=0; parity=0 when RCA_PARITY_EN is defined.

Source files
------------

// File: rtl/rca_operand_sequencer.sv
// -----------------------------------------------------------------------------
// rca_operand_sequencer
//
// Feeder and result-capture stage wrapped around an external, purely
// combinational WIDTH-bit ripple-carry adder.
//
//   * Deserialises operand A, then operand B, from a bit-serial valid/ready
//     stream (each operand LSB first).
//   * Holds both operands on a_out/b_out with op_valid high for SETTLE_CYCLES
//     cycles so the adder chain can settle.
//   * Captures {cout_in, sum_in} into a one-entry result slot that is offered
//     on a valid/ready result port.
//   * The next operand pair may be loaded while a result is still held. Only
//     the exit from SETTLE waits for the result slot to free.
//
// Parameters
//   WIDTH          operand width, must equal the adder width (4)
//   SETTLE_CYCLES  cycles op_valid is high before the adder is sampled (1..15)
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         synchronous reset, active-high, highest priority
//   ser_valid   serial bit valid
//   ser_ready   a serial bit is accepted this cycle (LOAD_A or LOAD_B)
//   ser_bit     serial operand bit: A bits first, then B bits, LSB first
//   a_out       operand A to the adder (bit i drives Ai)
//   b_out       operand B to the adder (bit i drives Bi)
//   op_valid    a_out/b_out complete and stable
//   sum_in      adder sum S[WIDTH-1:0]
//   cout_in     adder carry-out
//   res_valid   res_data holds an unconsumed result
//   res_ready   downstream accepts the result
//   res_data    {Cout, S[WIDTH-1:0]}
//   busy        high unless idle in LOAD_A with no bits received
//   res_parity  (only with RCA_PARITY_EN defined) XOR of all res_data bits,
//               registered at capture together with res_data
//
// Optional feature macro: RCA_PARITY_EN
// -----------------------------------------------------------------------------
module rca_operand_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    output logic             ser_ready,
    input  logic             ser_bit,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             op_valid,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_data,
    output logic             busy
`ifdef RCA_PARITY_EN
    ,
    output logic             res_parity
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [3:0]       settle_cnt, settle_cnt_next;
    logic [WIDTH-1:0] a_next, b_next;
    logic             op_valid_next;
    logic             res_valid_next;
    logic [WIDTH:0]   res_data_next;
    logic             xfer;
    logic             capture;

    // Ready is a pure decode of the registered state, so it never depends
    // combinationally on ser_valid.
    assign ser_ready = (state == LOAD_A) || (state == LOAD_B);
    assign xfer      = ser_valid && ser_ready;
    assign busy      = (state != LOAD_A) || (bit_cnt != '0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_A;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            a_out      <= '0;
            b_out      <= '0;
            op_valid   <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            settle_cnt <= settle_cnt_next;
            a_out      <= a_next;
            b_out      <= b_next;
            op_valid   <= op_valid_next;
            res_valid  <= res_valid_next;
            res_data   <= res_data_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        settle_cnt_next = settle_cnt;
        a_next          = a_out;
        b_next          = b_out;
        op_valid_next   = op_valid;
        res_valid_next  = res_valid;
        res_data_next   = res_data;
        capture         = 1'b0;

        // Drain first; a capture below in the same cycle overrides it so the
        // slot stays full with the new result.
        if (res_valid && res_ready) begin
            res_valid_next = 1'b0;
        end

        case (state)
            LOAD_A: begin
                if (xfer) begin
                    a_next = {ser_bit, a_out[WIDTH-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = LOAD_B;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

            LOAD_B: begin
                if (xfer) begin
                    b_next = {ser_bit, b_out[WIDTH-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_next    = '0;
                        settle_cnt_next = '0;
                        op_valid_next   = 1'b1;
                        state_next      = SETTLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

            SETTLE: begin
                if (settle_cnt != SETTLE_LAST) begin
                    settle_cnt_next = settle_cnt + 4'd1;
                end else if (!res_valid || res_ready) begin
                    capture        = 1'b1;
                    res_data_next  = {cout_in, sum_in};
                    res_valid_next = 1'b1;
                    op_valid_next  = 1'b0;
                    state_next     = LOAD_A;
                end
                // otherwise stall here with op_valid held high
            end

            default: begin
                state_next = LOAD_A;
            end
        endcase
    end

`ifdef RCA_PARITY_EN
    // ------------------------------------------------------------------
    // Result parity, registered alongside res_data
    // ------------------------------------------------------------------
    logic res_parity_next;

    always_comb begin
        res_parity_next = res_parity;
        if (capture) begin
            res_parity_next = ^{cout_in, sum_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_parity <= 1'b0;
        end else begin
            res_parity <= res_parity_next;
        end
    end
`endif

endmodule

// File: tb/tb_rca_operand_sequencer.sv
module tb_rca_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    // DUT with SETTLE_CYCLES = 1
    logic       ser_valid, ser_ready, ser_bit;
    logic [3:0] a_out, b_out, sum_in;
    logic       cout_in, op_valid, res_valid, res_ready, busy;
    logic [4:0] res_data;
    logic       res_parity;

    // DUT with SETTLE_CYCLES = 3
    logic       ser_valid3, ser_ready3, ser_bit3;
    logic [3:0] a_out3, b_out3, sum_in3;
    logic       cout_in3, op_valid3, res_valid3, res_ready3, busy3;
    logic [4:0] res_data3;
    logic       res_parity3;

    int checks   = 0;
    int failures = 0;

    // Behavioural stand-in for the external ripple-carry adder
    assign {cout_in, sum_in}   = 5'(a_out) + 5'(b_out);
    assign {cout_in3, sum_in3} = 5'(a_out3) + 5'(b_out3);

`ifndef RCA_PARITY_EN
    assign res_parity  = 1'b0;
    assign res_parity3 = 1'b0;
`endif

    rca_operand_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
        .a_out(a_out), .b_out(b_out), .op_valid(op_valid),
        .sum_in(sum_in), .cout_in(cout_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
`ifdef RCA_PARITY_EN
        , .res_parity(res_parity)
`endif
    );

    rca_operand_sequencer #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .ser_valid(ser_valid3), .ser_ready(ser_ready3), .ser_bit(ser_bit3),
        .a_out(a_out3), .b_out(b_out3), .op_valid(op_valid3),
        .sum_in(sum_in3), .cout_in(cout_in3),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
        .busy(busy3)
`ifdef RCA_PARITY_EN
        , .res_parity(res_parity3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_parity(input string name, input logic [4:0] exp_res);
`ifdef RCA_PARITY_EN
        chk(name, 32'(res_parity), 32'(^exp_res));
`else
        if (exp_res === 5'h1F) chk(name, 32'(res_parity), 32'd1);
`endif
    endtask

    // Called at a negedge; returns at the negedge after the bit transferred.
    task automatic send_bit(input logic b);
        int n = 0;
        ser_valid = 1'b1;
        ser_bit   = b;
        while (!ser_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ser_ready) chk("ser_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        ser_valid = 1'b0;
    endtask

    // Streams A then B (LSB first) with 'gap' idle cycles between bits.
    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input int gap);
        logic [7:0] s;
        s = {b, a};
        for (int i = 0; i < 8; i++) begin
            send_bit(s[i]);
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("busy_in_gap", 32'(busy), 32'd1);
                end
            end
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         gap;
        logic [4:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 4'h9, b: 4'h7, gap: 0, exp_res: 5'h10};
        vecs[1] = '{a: 4'h9, b: 4'h7, gap: 3, exp_res: 5'h10};
        vecs[2] = '{a: 4'h0, b: 4'h0, gap: 0, exp_res: 5'h00};
        vecs[3] = '{a: 4'h5, b: 4'hA, gap: 0, exp_res: 5'h0F};
        vecs[4] = '{a: 4'hC, b: 4'h6, gap: 1, exp_res: 5'h12};
        vecs[5] = '{a: 4'hF, b: 4'h1, gap: 0, exp_res: 5'h10};

        rst = 1'b1;
        ser_valid = 1'b0; ser_bit = 1'b0; res_ready = 1'b1;
        ser_valid3 = 1'b0; ser_bit3 = 1'b0; res_ready3 = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_a_out", 32'(a_out), 32'h0);
        chk("rst_b_out", 32'(b_out), 32'h0);
        chk("rst_op_valid", 32'(op_valid), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_parity", 32'(res_parity), 32'h0);
        rst = 1'b0;
        chk("rst_ser_ready", 32'(ser_ready), 32'h1);

        // Table-driven pairs, no backpressure
        for (int v = 0; v < 6; v++) begin
            send_pair(vecs[v].a, vecs[v].b, vecs[v].gap);
            chk("vec_op_valid", 32'(op_valid), 32'h1);
            chk("vec_a_out", 32'(a_out), 32'(vecs[v].a));
            chk("vec_b_out", 32'(b_out), 32'(vecs[v].b));
            chk("vec_res_valid_early", 32'(res_valid), 32'h0);
            chk("vec_ser_ready_settle", 32'(ser_ready), 32'h0);
            @(negedge clk);
            chk("vec_op_valid_clear", 32'(op_valid), 32'h0);
            chk("vec_res_valid", 32'(res_valid), 32'h1);
            chk("vec_res_data", 32'(res_data), 32'(vecs[v].exp_res));
            chk_parity("vec_parity", vecs[v].exp_res);
            @(negedge clk);
            chk("vec_res_drained", 32'(res_valid), 32'h0);
            chk("vec_idle_busy", 32'(busy), 32'h0);
        end

        // Backpressure: full slot stalls SETTLE; capture and drain coincide
        res_ready = 1'b0;
        send_pair(4'hF, 4'hF, 0);
        @(negedge clk);
        chk("bp_res_valid1", 32'(res_valid), 32'h1);
        chk("bp_res_data1", 32'(res_data), 32'h1E);
        send_pair(4'h1, 4'h2, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_stall_op_valid", 32'(op_valid), 32'h1);
            chk("bp_stall_ser_ready", 32'(ser_ready), 32'h0);
            chk("bp_stall_res_data", 32'(res_data), 32'h1E);
            chk("bp_stall_res_valid", 32'(res_valid), 32'h1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_swap_res_valid", 32'(res_valid), 32'h1);
        chk("bp_swap_res_data", 32'(res_data), 32'h03);
        chk("bp_swap_op_valid", 32'(op_valid), 32'h0);
        chk("bp_swap_ser_ready", 32'(ser_ready), 32'h1);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain", 32'(res_valid), 32'h0);

        // Reset mid-operation with a held result
        res_ready = 1'b0;
        send_pair(4'h5, 4'hA, 0);
        @(negedge clk);
        chk("mid_res_held", 32'(res_data), 32'h0F);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_res_valid", 32'(res_valid), 32'h0);
        chk("mid_rst_res_data", 32'(res_data), 32'h0);
        chk("mid_rst_a_out", 32'(a_out), 32'h0);
        chk("mid_rst_b_out", 32'(b_out), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ser_ready", 32'(ser_ready), 32'h1);
        chk("mid_rst_parity", 32'(res_parity), 32'h0);
        res_ready = 1'b1;
        send_pair(4'h3, 4'h4, 0);
        @(negedge clk);
        chk("mid_fresh_res_valid", 32'(res_valid), 32'h1);
        chk("mid_fresh_res_data", 32'(res_data), 32'h07);

        // SETTLE_CYCLES = 3: op_valid for exactly 3 cycles, result at t+4
        begin
            logic [7:0] s3;
            int n;
            s3 = 8'h88;
            for (int i = 0; i < 8; i++) begin
                ser_valid3 = 1'b1;
                ser_bit3   = s3[i];
                chk("s3_ser_ready", 32'(ser_ready3), 32'h1);
                @(negedge clk);
            end
            ser_valid3 = 1'b0;
            n = 0;
            while (op_valid3 && n < 10) begin
                chk("s3_res_valid_early", 32'(res_valid3), 32'h0);
                n++;
                @(negedge clk);
            end
            chk("s3_op_valid_cycles", 32'(n), 32'd3);
            chk("s3_res_valid", 32'(res_valid3), 32'h1);
            chk("s3_res_data", 32'(res_data3), 32'h10);
`ifdef RCA_PARITY_EN
            chk("s3_parity", 32'(res_parity3), 32'h1);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
